// File: rtl/uart_tx_param_pkg.sv
// Shared UART definitions: parity selectors, transmitter FSM encoding and
// the rounded baud-divider helper. The receiver uses the same helper, so
// both ends of a link agree on the bit period.
package uart_tx_param_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // System clocks per bit, rounded to the nearest integer.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART transmitter.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (empties the FIFO)
//   push, wdata   - write request and data; ignored when full
//   pop           - remove head entry; ignored when empty
//   rdata         - head entry, valid combinationally while !empty
//   full, empty   - derived from the level counter
//   level         - number of stored entries
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full  = (level_q == FULL_LEVEL);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (!do_push && do_pop) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; the level counter alone decides validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with an input FIFO and internal baud enable.
// Ports:
//   clk, rst    - system clock, synchronous active-high reset
//   in_data     - word to send (DATA_BITS wide), taken when in_valid & in_ready
//   in_valid    - producer offers in_data
//   in_ready    - FIFO can accept (low while full or in reset)
//   tx          - serial line, idles high
//   busy        - frame in progress or words still queued
//   fifo_level  - current FIFO entry count
module uart_tx_param
    import uart_tx_param_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int DIV   = baud_div(CLK_HZ, BAUD);
    localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int BIT_W = $clog2(DATA_BITS);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_param: clocks per bit must be at least 2");
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 tx_q, tx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;

    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 cnt_last, last_data, last_stop;

    // A full FIFO refuses a push even if a pop frees a slot on the same edge.
    assign in_ready  = !fifo_full && !rst;
    assign fifo_push = in_valid && in_ready;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign cnt_last  = (cnt_q == CNT_W'(DIV - 1));
    assign last_data = (bit_idx_q == BIT_W'(DATA_BITS - 1));
    assign last_stop = (stop_idx_q == 1'(STOP_BITS - 1));

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        tx_d       = tx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        fifo_pop   = 1'b0;
        // Counter runs only while a frame is on the line and wraps at each bit boundary.
        cnt_d      = (state_q == ST_IDLE || cnt_last) ? '0 : cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                end
            end
            ST_START: begin
                if (cnt_last) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                if (cnt_last) begin
                    if (!last_data) begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end else if (PARITY != PARITY_NONE) begin
                        state_d = ST_PARITY;
                        tx_d    = par_q;
                    end else begin
                        state_d    = ST_STOP;
                        stop_idx_d = 1'b0;
                        tx_d       = 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (cnt_last) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_last) begin
                    if (!last_stop) begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next start bit, no idle cycle.
                        fifo_pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Loading a new word: capture it, precompute parity, drive the start bit.
        if (fifo_pop) begin
            shift_d = fifo_rdata;
            par_d   = (PARITY == PARITY_ODD) ? ~^fifo_rdata : ^fifo_rdata;
            state_d = ST_START;
            cnt_d   = '0;
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign tx   = tx_q;
    assign busy = (state_q != ST_IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: five differently parametrised instances share
// clock and reset; one is selected at a time for the line monitor.
`timescale 1ns/1ps
module tb_uart_tx_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [7:0]      in_data;
    logic [4:0]      in_valid;
    logic [4:0]      in_ready;
    logic [4:0]      tx;
    logic [4:0]      busy;
    logic [4:0][2:0] lvl;

    logic [2:0]      sel;
    logic            tx_mux, busy_mux;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames_seen = 0;

    // Line monitor configuration and expected-word queue.
    int  exp_q [$];
    int  m_div, m_dbits, m_par, m_stop;
    bit  mon_en = 1'b0;
    bit  mon_active = 1'b0;
    bit  b2b_en = 1'b0;
    bit  have_prev = 1'b0;
    int  prev_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        tx_mux   = 1'b1;
        busy_mux = 1'b0;
        case (sel)
            3'd0: begin tx_mux = tx[0]; busy_mux = busy[0]; end
            3'd1: begin tx_mux = tx[1]; busy_mux = busy[1]; end
            3'd2: begin tx_mux = tx[2]; busy_mux = busy[2]; end
            3'd3: begin tx_mux = tx[3]; busy_mux = busy[3]; end
            3'd4: begin tx_mux = tx[4]; busy_mux = busy[4]; end
            default: begin tx_mux = 1'b1; busy_mux = 1'b0; end
        endcase
    end

    uart_tx_param u_def (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .tx(tx[0]), .busy(busy[0]), .fifo_level(lvl[0])
    );
    uart_tx_param #(.PARITY(2)) u_even (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .tx(tx[1]), .busy(busy[1]), .fifo_level(lvl[1])
    );
    uart_tx_param #(.PARITY(1)) u_odd (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .tx(tx[2]), .busy(busy[2]), .fifo_level(lvl[2])
    );
    uart_tx_param #(.DATA_BITS(7), .STOP_BITS(2)) u_s2 (
        .clk(clk), .rst(rst), .in_data(in_data[6:0]), .in_valid(in_valid[3]),
        .in_ready(in_ready[3]), .tx(tx[3]), .busy(busy[3]), .fifo_level(lvl[3])
    );
    uart_tx_param #(.CLK_HZ(100), .BAUD(30)) u_fast (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid[4]),
        .in_ready(in_ready[4]), .tx(tx[4]), .busy(busy[4]), .fifo_level(lvl[4])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at the first sample of a start bit; walks the whole frame
    // cycle by cycle against the expected word at the queue head.
    task automatic check_frame();
        int exp_d;
        int s;
        int nbits;
        int ones;
        int bad;
        logic [15:0] bits;
        mon_active = 1'b1;
        s = cyc;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame_expected: frame started at cycle %0d with no word queued", s);
            exp_d = 0;
        end else begin
            exp_d = exp_q.pop_front();
        end
        bits = '1;
        bits[0] = 1'b0;
        nbits = 1;
        for (int i = 0; i < m_dbits; i++) begin
            bits[nbits] = exp_d[i];
            nbits++;
        end
        ones = $countones(exp_d & ((1 << m_dbits) - 1));
        if (m_par == 1) begin
            bits[nbits] = ((ones % 2) == 0);
            nbits++;
        end else if (m_par == 2) begin
            bits[nbits] = ((ones % 2) == 1);
            nbits++;
        end
        for (int i = 0; i < m_stop; i++) begin
            bits[nbits] = 1'b1;
            nbits++;
        end
        if (b2b_en && have_prev) begin
            chk("frame_start_spacing", s - prev_start, nbits * m_div);
        end
        prev_start = s;
        have_prev  = 1'b1;
        for (int b = 0; b < nbits; b++) begin
            bad = 0;
            for (int c = 0; c < m_div; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (tx_mux !== bits[b]) bad++;
            end
            chk($sformatf("word_%0h_bit%0d_wrong_cycles", exp_d, b), bad, 0);
        end
        frames_seen++;
        mon_active = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mon_en && tx_mux === 1'b0) check_frame();
        end
    end

    // Offer one word; returns after the push edge, at the following negedge.
    task automatic push_item(input logic [2:0] idx, input logic [7:0] d, output int waited);
        waited = 0;
        in_data = d;
        in_valid[idx] = 1'b1;
        while (!in_ready[idx] && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready[idx]) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: in_ready still %0b after %0d cycles, required 1", in_ready[idx], waited);
        end else begin
            exp_q.push_back(int'(d));
        end
        @(negedge clk);
        in_valid[idx] = 1'b0;
    endtask

    task automatic measure_frame(input string name, input int exp_len);
        int t;
        int len;
        t = 0;
        len = 0;
        while (tx_mux !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_start_latency"}, t, 1);
        while (busy_mux && len < exp_len + 100) begin
            @(negedge clk);
            len++;
        end
        chk({name, "_busy_cycles"}, len, exp_len);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || mon_active || busy_mux) && t < budget) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= budget) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, %0d words unsent, required idle", name, t, exp_q.size());
        end
    endtask

    task automatic config_mon(input logic [2:0] s, input int div, input int dbits,
                              input int par, input int stop, input bit b2b);
        sel = s;
        m_div = div;
        m_dbits = dbits;
        m_par = par;
        m_stop = stop;
        b2b_en = b2b;
        have_prev = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int w;
        int first_block;
        int f0;
        int low_cycles;
        rst = 1'b1;
        in_valid = '0;
        in_data = '0;
        sel = 3'd0;
        m_div = 1250; m_dbits = 8; m_par = 0; m_stop = 1;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_tx", int'(tx), 31);
        chk("reset_busy", int'(busy), 0);
        chk("reset_level_def", int'(lvl[0]), 0);
        chk("reset_level_fast", int'(lvl[4]), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", int'(in_ready), 31);
        mon_en = 1'b1;

        // 8N1 at 1250 clocks per bit: 'D' = 0x44.
        config_mon(3'd0, 1250, 8, 0, 1, 1'b0);
        push_item(3'd0, 8'h44, w);
        measure_frame("def_44", 12500);
        wait_idle("def_idle", 200);

        // Even then odd parity; 0x44 has two ones.
        config_mon(3'd1, 1250, 8, 2, 1, 1'b0);
        push_item(3'd1, 8'h44, w);
        measure_frame("even_44", 13750);
        wait_idle("even_idle", 200);

        config_mon(3'd2, 1250, 8, 1, 1, 1'b0);
        push_item(3'd2, 8'h44, w);
        measure_frame("odd_44", 13750);
        wait_idle("odd_idle", 200);

        // Seven data bits, two stop bits.
        config_mon(3'd3, 1250, 7, 0, 2, 1'b0);
        push_item(3'd3, 8'h7F, w);
        measure_frame("s2_7f", 12500);
        wait_idle("s2_idle", 200);

        // 100 Hz / 30 baud rounds to 3 clocks per bit; push coinciding with pop.
        config_mon(3'd4, 3, 8, 0, 1, 1'b1);
        push_item(3'd4, 8'hA5, w);
        chk("level_after_first_push", int'(lvl[4]), 1);
        push_item(3'd4, 8'h3C, w);
        chk("level_push_pop_same_edge", int'(lvl[4]), 1);
        wait_idle("fast_pair_idle", 500);

        // Burst of six with in_valid held: five accepted before in_ready drops.
        config_mon(3'd4, 3, 8, 0, 1, 1'b1);
        f0 = frames_seen;
        first_block = -1;
        for (int i = 1; i <= 6; i++) begin
            push_item(3'd4, 8'(i), w);
            if (w > 0 && first_block < 0) first_block = i - 1;
        end
        chk("pushes_before_ready_low", first_block, 5);
        wait_idle("burst_idle", 1000);
        chk("burst_frame_count", frames_seen - f0, 6);
        b2b_en = 1'b0;

        // Reset in the middle of the data bits with two words still queued.
        mon_en = 1'b0;
        config_mon(3'd4, 3, 8, 0, 1, 1'b0);
        push_item(3'd4, 8'h00, w);
        push_item(3'd4, 8'h22, w);
        push_item(3'd4, 8'h33, w);
        exp_q.delete();
        repeat (4) @(negedge clk);
        chk("mid_frame_tx_low", int'(tx[4]), 0);
        chk("mid_frame_level", int'(lvl[4]), 2);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_tx", int'(tx[4]), 1);
        chk("rst_mid_level", int'(lvl[4]), 0);
        chk("rst_mid_in_ready", int'(in_ready[4]), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_mid_rst", int'(in_ready[4]), 1);
        low_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx[4] !== 1'b1) low_cycles++;
            @(negedge clk);
        end
        chk("no_frame_after_rst", low_cycles, 0);
        chk("busy_after_rst", int'(busy[4]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
